// File: rtl/foo_bar_pkg.sv
// foo_bar_pkg
//   Shared definitions for the foo/bar periodic pulse interface.
//   FOO_PERIOD_DEF / BAR_PERIOD_DEF : default pulse periods, also used by
//                                     the foo_bar generator so both sides agree.
//   state_t                         : checker state (IDLE, ARMED).
package foo_bar_pkg;

  localparam int unsigned FOO_PERIOD_DEF = 2;
  localparam int unsigned BAR_PERIOD_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/foo_bar_period_checker.sv
// foo_bar_period_checker
//   Checks one periodic pulse stream against its expected phase.
//   Parameters:
//     PERIOD     : cycles between start and first pulse, and between pulses (>=1)
//     CHECK_IDLE : when 1, any pulse seen while not armed is flagged as extra
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     start      : (re)loads the phase counter; its cycle is never checked
//     armed      : checker FSM is in ARMED this cycle
//     pulse      : observed pulse
//     miss       : registered, pulse expected but absent
//     extra      : registered, pulse present but not expected
module foo_bar_period_checker
  import foo_bar_pkg::*;
#(
  parameter int unsigned PERIOD     = FOO_PERIOD_DEF,
  parameter bit          CHECK_IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic armed,
  input  logic pulse,
  output logic miss,
  output logic extra
);

  localparam int unsigned     PW        = $clog2(PERIOD + 1);
  localparam logic [PW-1:0]   PHASE_MAX = PW'(PERIOD);
  localparam logic [PW-1:0]   PHASE_ONE = PW'(1);

  logic [PW-1:0] phase;
  logic          expected;

  // The phase counts 1..PERIOD; a pulse is due when it sits at PERIOD.
  assign expected = armed && (phase == PHASE_MAX);

  // Phase counter plus registered miss/extra flags. The start cycle reloads
  // the phase to 1 so the first pulse lands PERIOD cycles after start, and
  // samples in that cycle are ignored because the old phase no longer applies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      miss  <= 1'b0;
      extra <= 1'b0;
    end else begin
      miss  <= 1'b0;
      extra <= 1'b0;
      if (start) begin
        phase <= PHASE_ONE;
      end else if (armed) begin
        phase <= (phase == PHASE_MAX) ? PHASE_ONE : phase + PHASE_ONE;
        miss  <= expected && !pulse;
        extra <= !expected && pulse;
      end else if (CHECK_IDLE) begin
        extra <= pulse;
      end
    end
  end

endmodule

// File: rtl/foo_bar_checker.sv
// foo_bar_checker
//   Receive-side checker / passive monitor for the foo/bar pulse interface.
//   Parameters:
//     FOO_PERIOD, BAR_PERIOD : expected pulse periods (>=1)
//     ERR_W                  : width of the saturating error counter
//     CHECK_IDLE             : flag pulses seen while IDLE as extra
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     start_i         : (re)arms and re-phases the checker
//     stop_i          : return to IDLE (start_i has priority)
//     foo_i, bar_i    : observed pulses
//     err_clr_i       : synchronous clear of err_count_o (wins over new errors)
//     armed_o         : high while ARMED
//     foo_miss_o, foo_extra_o, bar_miss_o, bar_extra_o : one-cycle error flags,
//                       one cycle after the offending sample
//     err_count_o     : saturating count of all error flags
module foo_bar_checker
  import foo_bar_pkg::*;
#(
  parameter int unsigned FOO_PERIOD = FOO_PERIOD_DEF,
  parameter int unsigned BAR_PERIOD = BAR_PERIOD_DEF,
  parameter int unsigned ERR_W      = 8,
  parameter bit          CHECK_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             foo_i,
  input  logic             bar_i,
  input  logic             err_clr_i,
  output logic             armed_o,
  output logic             foo_miss_o,
  output logic             foo_extra_o,
  output logic             bar_miss_o,
  output logic             bar_extra_o,
  output logic [ERR_W-1:0] err_count_o
);

  // Wide enough to hold the counter plus up to four flags without overflow.
  localparam int unsigned      SW      = ERR_W + 3;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic             in_armed;
  logic [2:0]       raised;
  logic [SW-1:0]    sum_wide;
  logic [ERR_W-1:0] count_next;

  assign in_armed = (state == ARMED);

  // FSM with armed_o registered alongside the state; start beats stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      armed_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= ARMED;
            armed_o <= 1'b1;
          end
        end
        ARMED: begin
          if (!start_i && stop_i) begin
            state   <= IDLE;
            armed_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          armed_o <= 1'b0;
        end
      endcase
    end
  end

  foo_bar_period_checker #(
    .PERIOD     (FOO_PERIOD),
    .CHECK_IDLE (CHECK_IDLE)
  ) u_foo (
    .clk   (clk),
    .rst   (rst),
    .start (start_i),
    .armed (in_armed),
    .pulse (foo_i),
    .miss  (foo_miss_o),
    .extra (foo_extra_o)
  );

  foo_bar_period_checker #(
    .PERIOD     (BAR_PERIOD),
    .CHECK_IDLE (CHECK_IDLE)
  ) u_bar (
    .clk   (clk),
    .rst   (rst),
    .start (start_i),
    .armed (in_armed),
    .pulse (bar_i),
    .miss  (bar_miss_o),
    .extra (bar_extra_o)
  );

  // The counter accumulates the flags currently on the outputs, so a count
  // step lands one cycle after its flag. Saturate instead of wrapping.
  always_comb begin
    raised     = 3'(foo_miss_o) + 3'(foo_extra_o) + 3'(bar_miss_o) + 3'(bar_extra_o);
    sum_wide   = SW'(err_count_o) + SW'(raised);
    count_next = (sum_wide > SW'(ERR_MAX)) ? ERR_MAX : sum_wide[ERR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_o <= '0;
    end else if (err_clr_i) begin
      err_count_o <= '0;
    end else begin
      err_count_o <= count_next;
    end
  end

endmodule

// File: doc/foo_bar_checker.md
Name: foo_bar_checker

Overview:
- Receive-side checker for the foo/bar periodic pulse interface driven by foo_bar.
- Observes start, foo and bar. Verifies that foo pulses every FOO_PERIOD cycles and bar every BAR_PERIOD cycles, phase-aligned to the last start.
- Flags missing and spurious pulses and keeps a saturating error count.
- Sits beside the generator in the integration and is also reused as a passive protocol monitor in benches.

Parameters:
- FOO_PERIOD, 2, cycles between start and first foo, and between consecutive foo pulses (>=1).
- BAR_PERIOD, 3, same for bar (>=1).
- ERR_W, 8, width of the saturating error counter.
- CHECK_IDLE, 1, if 1 any foo/bar high while IDLE counts as a spurious error; if 0, IDLE is unchecked.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  same start pulse seen by the generator; (re)arms and re-phases the checker
- stop_i  input  1  return to IDLE; checking stops
- foo_i  input  1  observed foo pulse
- bar_i  input  1  observed bar pulse
- err_clr_i  input  1  synchronous clear of err_count_o
- armed_o  output  1  high while in ARMED
- foo_miss_o  output  1  one-cycle pulse: foo expected but low
- foo_extra_o  output  1  one-cycle pulse: foo high when not expected
- bar_miss_o  output  1  one-cycle pulse: bar expected but low
- bar_extra_o  output  1  one-cycle pulse: bar high when not expected
- err_count_o  output  ERR_W  saturating count of all error events

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; both phase counters=0.
  - All outputs 0, err_count_o=0.
- States:
  - IDLE -> ARMED when start_i=1 at an edge.
  - ARMED -> IDLE when stop_i=1 and start_i=0.
  - ARMED + start_i=1 -> ARMED with phases reloaded (restart).
  - start_i and stop_i together: start wins.
- Phase counters, one per stream, width clog2(PERIOD+1):
  - Load 1 at the edge where start_i is sampled.
  - Otherwise, in ARMED, increment; PERIOD wraps to 1.
  - Expected(stream) = ARMED && phase==PERIOD.
  - Example: start high in cycle 0 -> foo expected in cycles 2,4,6…; bar in cycles 3,6,9….
- Checking, per stream, in ARMED:
  - expected && !pulse -> miss.
  - !expected && pulse -> extra.
  - Samples in the cycle where start_i=1 are not checked, for any state.
- In IDLE with CHECK_IDLE=1: pulse high -> extra. The stop cycle itself is still checked as ARMED.
- Output latency:
  - Error flags are registered and assert exactly 1 cycle after the offending sample, for 1 cycle.
  - armed_o is registered state; it rises the cycle after start is sampled.
- err_count_o:
  - Adds the number of error flags raised that cycle (0..2; miss and extra of the same stream are mutually exclusive).
  - Saturates at 2^ERR_W-1 and never wraps.
  - err_clr_i=1 zeroes it; errors in the same cycle are dropped, i.e. clear wins.
- Same cycle on both streams (e.g. cycle 6 at default periods): both streams are checked independently; foo and bar errors may both fire.
- Reset mid-operation: immediate return to IDLE with counts cleared; no error flagged for pulses interrupted by reset.
- PERIOD=1: pulse is expected every ARMED cycle after start.

Decomposition:
- Package foo_bar_pkg holds:
  - FOO_PERIOD_DEF=2 and BAR_PERIOD_DEF=3 constants, shared with foo_bar.
  - State enum {IDLE, ARMED}.
- Sub-module foo_bar_period_checker (params PERIOD), instantiated twice:
  - Inputs: start, armed, pulse.
  - Outputs: registered miss/extra.
  - Contains the phase counter.
- Top holds the FSM and the saturating error counter.

Test Plan:
- Golden: foo_bar drives foo/bar; start at cycle 0, run 30 cycles -> no error flags, err_count_o=0, armed_o=1 from cycle 1.
- Missing foo: start at 0, suppress foo in cycle 4 -> foo_miss_o=1 in cycle 5 only, err_count_o=1 in cycle 6.
- Spurious bar plus coincidence: start at 0; bar high in cycle 4 and foo dropped in cycle 6 -> bar_extra_o at 5, foo_miss_o at 7, err_count_o=2.
- Restart: start at 0, start again at 5, foo at 7,9, bar at 8 -> no errors; old-phase cycle 6 pulse absent is not a miss.
- Idle and stop: foo high at cycle 2 before any start -> foo_extra_o at 3. Then start at 10, stop at 13 with bar held low at 13 -> bar_miss_o at 14, armed_o=0 from 14.
- Saturation, clear and reset: ERR_W=2, inject 5 extras -> count sticks at 3. err_clr_i with a simultaneous error -> 0. Assert rst mid-run -> all outputs 0 immediately.
